snes_pad_poller: RTL and testbench

- Initiator end of the SNES joypad serial protocol, for reading a physical SNES controller wired to ULX3S GPIO.
- Periodically drives latch and clock to the pad and shifts in 16 active-low button bits plus one presence bit.
- Publishes an active-high 16-bit button word that the top level feeds into its console-side joypad shift register, in place of or merged with the ESP32 pad.
- Runs in the clk_sys domain.

---
 rtl/snes_pad_pkg.sv | 34 +++
 rtl/sync2.sv | 32 +++
 rtl/snes_pad_poller.sv | 139 +++++++++++++
 tb/tb_snes_pad_poller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_pkg
// Description : Shared types and constants for the SNES joypad poller.
// Revision    : 1.0 - initial release
// ============================================================================
package snes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } pad_state_t;

    localparam int PAD_BITS    = 16;
    localparam int PAD_SAMPLES = 17;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for a single asynchronous input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/snes_pad_poller.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_poller
// Description : Periodically latches and clocks a SNES pad, publishing an
//               active-high button word and a presence flag.
// Revision    : 1.0 - initial release
// ============================================================================
module snes_pad_poller #(
    parameter int LATCH_CYCLES = 258,
    parameter int HALF_CYCLES  = 129,
    parameter int POLL_CYCLES  = 357955
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] buttons,
    output logic        present,
    output logic        valid,
    output logic        busy
);
    import snes_pad_pkg::*;

    localparam logic [15:0] C_LATCH_RELOAD = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0] C_HALF_RELOAD  = 16'(HALF_CYCLES - 1);
    localparam logic [18:0] C_POLL_LAST    = 19'(POLL_CYCLES - 1);
    localparam logic [4:0]  C_LAST_BIT     = 5'(PAD_BITS);

    pad_state_t  r_state;
    pad_state_t  w_state_next;
    logic [15:0] r_phase;
    logic [15:0] w_phase_load;
    logic [4:0]  r_bit;
    logic [18:0] r_timer;
    logic        r_first;
    logic [15:0] r_shift;
    logic        r_pad_latch;
    logic        r_pad_clk;
    logic [15:0] r_buttons;
    logic        r_present;
    logic        r_valid;
    logic        r_busy;
    logic        w_sync;
    logic        w_phase_done;
    logic        w_start;
    logic        w_enter;

    sync2 #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (pad_data),
        .o_q (w_sync)
    );

    assign w_phase_done = (r_phase == 16'd0);
    assign w_start      = enable && (r_first || (r_timer == C_POLL_LAST));
    assign w_enter      = (w_state_next != r_state);

    always_comb begin
        w_state_next = r_state;
        w_phase_load = C_HALF_RELOAD;
        case (r_state)
            IDLE:    if (w_start) w_state_next = LATCH;
            LATCH:   if (w_phase_done) w_state_next = HIGH;
            HIGH:    if (w_phase_done) w_state_next = (r_bit == C_LAST_BIT) ? DONE : LOW;
            LOW:     if (w_phase_done) w_state_next = HIGH;
            // An overrunning poll leaves the timer saturated, so restart immediately
            DONE:    w_state_next = w_start ? LATCH : IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_state_next == LATCH) w_phase_load = C_LATCH_RELOAD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_phase     <= 16'd0;
            r_bit       <= 5'd0;
            r_timer     <= 19'd0;
            r_first     <= 1'b1;
            r_shift     <= 16'hFFFF;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
            r_buttons   <= 16'd0;
            r_present   <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_enter) begin
                r_phase <= w_phase_load;
            end else if (r_state != IDLE) begin
                r_phase <= r_phase - 16'd1;
            end

            if ((w_state_next == LATCH) && (r_state != LATCH)) begin
                r_timer <= 19'd0;
                r_first <= 1'b0;
            end else if (r_timer != C_POLL_LAST) begin
                r_timer <= r_timer + 19'd1;
            end

            if (r_state == LATCH) begin
                r_bit <= 5'd0;
            end else if ((r_state == LOW) && w_phase_done) begin
                r_bit <= r_bit + 5'd1;
            end

            // Sample k lands in bit k once all sixteen have been shifted in
            if ((r_state == HIGH) && w_phase_done && (r_bit != C_LAST_BIT)) begin
                r_shift <= {w_sync, r_shift[15:1]};
            end

            r_valid <= (w_state_next == DONE);
            if (w_state_next == DONE) begin
                r_present <= ~w_sync;
                r_buttons <= w_sync ? 16'd0 : ~r_shift;
            end

            r_pad_latch <= (w_state_next == LATCH);
            r_pad_clk   <= (w_state_next != LOW);
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign buttons   = r_buttons;
    assign present   = r_present;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_poller.sv
`default_nettype none
// ============================================================================
// Module      : tb_snes_pad_poller
// Description : Self-checking bench with behavioural SNES pad models.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snes_pad_poller;

    localparam int C_LATCH  = 4;
    localparam int C_HALF   = 4;
    localparam int C_POLL   = 200;
    localparam int C_POLL_B = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        enable_b = 1'b1;
    logic        pad_data;
    logic        pad_latch, pad_clk, present, valid, busy;
    logic [15:0] buttons;
    logic        pad_data_b;
    logic        pad_latch_b, pad_clk_b, present_b, valid_b, busy_b;
    logic [15:0] buttons_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snes_pad_poller #(.LATCH_CYCLES(C_LATCH), .HALF_CYCLES(C_HALF), .POLL_CYCLES(C_POLL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .present(present), .valid(valid), .busy(busy)
    );

    snes_pad_poller #(.LATCH_CYCLES(C_LATCH), .HALF_CYCLES(C_HALF), .POLL_CYCLES(C_POLL_B)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .pad_data(pad_data_b),
        .pad_latch(pad_latch_b), .pad_clk(pad_clk_b), .buttons(buttons_b),
        .present(present_b), .valid(valid_b), .busy(busy_b)
    );

    // Pad models: parallel load while latched, shift on pad_clk rise, zeros after 16 bits
    logic [15:0] pressed_a = 16'h0000;
    bit          conn_a    = 1'b1;
    logic [31:0] sr_a      = '1;
    always @(posedge pad_clk or posedge pad_latch)
        if (pad_latch) sr_a <= {16'h0000, ~pressed_a};
        else           sr_a <= {1'b0, sr_a[31:1]};
    assign pad_data = conn_a ? sr_a[0] : 1'b1;

    logic [15:0] pressed_b = 16'h0000;
    logic [15:0] loaded_b  = 16'h0000;
    logic [31:0] sr_b      = '1;
    always @(posedge pad_clk_b or posedge pad_latch_b)
        if (pad_latch_b) begin
            sr_b     <= {16'h0000, ~pressed_b};
            loaded_b <= pressed_b;
        end else begin
            sr_b <= {1'b0, sr_b[31:1]};
        end
    assign pad_data_b = sr_b[0];

    int   latch_prev = -1;
    int   latch_last = -1;
    logic latch_q    = 1'b0;
    always @(negedge clk) begin
        latch_q <= pad_latch;
        if (pad_latch && !latch_q) begin
            latch_prev <= latch_last;
            latch_last <= cyc;
        end
    end

    // Observes one poll of dut up to and one cycle past its valid pulse
    task automatic wait_poll(input int budget, output bit timed_out, output int latch_cyc,
                             output int falls, output int valid_cyc);
        logic prev_clk;
        prev_clk  = pad_clk;
        timed_out = 1'b1;
        latch_cyc = 0;
        falls     = 0;
        valid_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pad_latch) latch_cyc++;
            if (prev_clk && !pad_clk) falls++;
            prev_clk = pad_clk;
            if (valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!timed_out) begin
            @(negedge clk);
            valid_cyc = valid ? 2 : 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (pad_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b want=0", pad_latch); end
        total++; if (pad_clk !== 1'b1) begin bad++; $display("FAIL reset_padclk got=%b want=1", pad_clk); end
        total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL reset_buttons got=%h want=0000", buttons); end
        total++; if (present !== 1'b0) begin bad++; $display("FAIL reset_present got=%b want=0", present); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++; if ({pad_latch, busy} !== 2'b00) begin bad++; $display("FAIL idle_disabled got=%b want=00", {pad_latch, busy}); end
    endtask

    task automatic test_pressed_0f0f();
        bit to; int lc, fl, vc;
        pressed_a = 16'h0F0F;
        conn_a    = 1'b1;
        enable    = 1'b1;
        wait_poll(400, to, lc, fl, vc);
        total++; if (to) begin bad++; $display("FAIL p0f0f_timeout got=no_valid want=valid"); end
        total++; if (buttons !== 16'h0F0F) begin bad++; $display("FAIL p0f0f_buttons got=%h want=0f0f", buttons); end
        total++; if (present !== 1'b1) begin bad++; $display("FAIL p0f0f_present got=%b want=1", present); end
        total++; if (vc != 1) begin bad++; $display("FAIL p0f0f_valid_width got=%0d want=1", vc); end
        total++; if (fl != 16) begin bad++; $display("FAIL p0f0f_falls got=%0d want=16", fl); end
        total++; if (lc != C_LATCH) begin bad++; $display("FAIL p0f0f_latch_cycles got=%0d want=%0d", lc, C_LATCH); end
    endtask

    task automatic test_no_pad();
        bit to; int lc, fl, vc;
        conn_a = 1'b0;
        wait_poll(400, to, lc, fl, vc);
        total++; if (to) begin bad++; $display("FAIL nopad_timeout got=no_valid want=valid"); end
        total++; if (buttons !== 16'h0000) begin bad++; $display("FAIL nopad_buttons got=%h want=0000", buttons); end
        total++; if (present !== 1'b0) begin bad++; $display("FAIL nopad_present got=%b want=0", present); end
        total++; if (vc != 1) begin bad++; $display("FAIL nopad_valid_width got=%0d want=1", vc); end
        wait_poll(400, to, lc, fl, vc);
        total++; if (latch_last - latch_prev != C_POLL) begin
            bad++; $display("FAIL poll_period got=%0d want=%0d", latch_last - latch_prev, C_POLL);
        end
    endtask

    task automatic test_change();
        bit to; int lc, fl, vc;
        bit stable, seen;
        conn_a    = 1'b1;
        pressed_a = 16'h0001 << 8;
        wait_poll(400, to, lc, fl, vc);
        total++; if (buttons !== 16'h0100) begin bad++; $display("FAIL change_first got=%h want=0100", buttons); end
        pressed_a = 16'h0001 << 3;
        stable = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid) begin seen = 1'b1; break; end
            if (buttons !== 16'h0100) stable = 1'b0;
        end
        total++; if (!seen) begin bad++; $display("FAIL change_timeout got=no_valid want=valid"); end
        total++; if (!stable) begin bad++; $display("FAIL change_stable got=changed want=held"); end
        total++; if (buttons !== 16'h0008) begin bad++; $display("FAIL change_second got=%h want=0008", buttons); end
    endtask

    task automatic test_random();
        bit to; int lc, fl, vc;
        logic [15:0] exp_btn;
        for (int n = 0; n < 5; n++) begin
            pressed_a = 16'($urandom);
            conn_a    = 1'($urandom_range(0, 1));
            exp_btn   = conn_a ? pressed_a : 16'h0000;
            wait_poll(400, to, lc, fl, vc);
            total++; if (to || buttons !== exp_btn || present !== conn_a) begin
                bad++; $display("FAIL random_%0d got=%h/%b want=%h/%b", n, buttons, present, exp_btn, conn_a);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit to; int lc, fl, vc;
        bit started, relatched;
        conn_a    = 1'b1;
        pressed_a = 16'h0A5A;
        started   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pad_latch) begin started = 1'b1; break; end
        end
        total++; if (!started) begin bad++; $display("FAIL drop_start got=no_latch want=latch"); end
        repeat (19) @(negedge clk);
        enable = 1'b0;
        wait_poll(400, to, lc, fl, vc);
        total++; if (to || buttons !== 16'h0A5A) begin bad++; $display("FAIL drop_complete got=%h want=0a5a", buttons); end
        relatched = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pad_latch || busy) relatched = 1'b1;
        end
        total++; if (relatched) begin bad++; $display("FAIL drop_no_new_poll got=poll want=idle"); end
        enable = 1'b1;
        @(negedge clk);
        total++; if (pad_latch !== 1'b1) begin bad++; $display("FAIL reenable_latch got=%b want=1", pad_latch); end
    endtask

    task automatic test_async_reset();
        bit to; int lc, fl, vc;
        bit in_low;
        logic [15:0] exp_btn;
        in_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pad_clk) begin in_low = 1'b1; break; end
        end
        total++; if (!in_low) begin bad++; $display("FAIL arst_low_phase got=none want=low"); end
        #2 reset = 1'b1;
        #1;
        total++; if ({pad_clk, pad_latch, buttons, present, busy} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            bad++; $display("FAIL arst_outputs got=%b%b_%h_%b%b want=10_0000_00", pad_clk, pad_latch, buttons, present, busy);
        end
        pressed_a = 16'($urandom);
        conn_a    = 1'b1;
        exp_btn   = pressed_a;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if ({pad_latch, busy} !== 2'b11) begin bad++; $display("FAIL arst_first_latch got=%b want=11", {pad_latch, busy}); end
        wait_poll(400, to, lc, fl, vc);
        total++; if (to || buttons !== exp_btn || present !== 1'b1) begin
            bad++; $display("FAIL arst_poll got=%h/%b want=%h/1", buttons, present, exp_btn);
        end
    endtask

    task automatic test_back_to_back();
        bit overlap, seen;
        for (int n = 0; n < 3; n++) begin
            overlap = 1'b0;
            seen    = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (pad_latch_b && !pad_clk_b) overlap = 1'b1;
                if (valid_b) begin seen = 1'b1; break; end
            end
            total++; if (!seen || overlap) begin bad++; $display("FAIL b2b_%0d_poll got=seen%b_overlap%b want=seen1_overlap0", n, seen, overlap); end
            total++; if (buttons_b !== loaded_b || present_b !== 1'b1) begin
                bad++; $display("FAIL b2b_%0d_buttons got=%h/%b want=%h/1", n, buttons_b, present_b, loaded_b);
            end
            pressed_b = 16'($urandom);
            @(negedge clk);
            total++; if (pad_latch_b !== 1'b1) begin bad++; $display("FAIL b2b_%0d_restart got=%b want=1", n, pad_latch_b); end
        end
    endtask

    initial begin
        pressed_b = 16'($urandom);
        test_reset();
        test_pressed_0f0f();
        test_no_pad();
        test_change();
        test_random();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
